// File: rtl/uart_pkg.sv
// Shared types and constants for the MMIO UART receiver.
// Pure declarations; no logic, no latency.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

  localparam int ST_VALID = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVR   = 2;
  localparam int ST_FERR  = 3;

  localparam logic [15:0] OFS_DATA   = 16'd0;
  localparam logic [15:0] OFS_STATUS = 16'd1;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO; head is visible combinationally, push/pop commit on the clock edge.
// A push into a full FIFO is accepted only when a pop happens in the same cycle; a pop on empty is ignored.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];

  // Popping frees the slot the push lands in, so a full FIFO can still take a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with receive FIFO and DATA/STATUS MMIO registers.
// Byte pushed one cycle after the mid-stop sample; MMIO done one cycle after req; full FIFO drops bytes and flags overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int          CLK_FREQ   = 27_000_000,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] BASE_ADDR  = 16'hFF10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  input  logic [15:0] mmio_addr,
  input  logic [7:0]  mmio_data,
  input  logic        mmio_write,
  input  logic        mmio_req,
  output logic        mmio_done,
  output logic [7:0]  mmio_rdata,
  output logic        rx_ready
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CPB - 1);

  logic [1:0]    sync_q, sync_d;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          armed_q, armed_d;
  logic          push_q, push_d;
  logic          ferr_set;
  logic          line;

  logic          served_q, served_d;
  logic          done_q, done_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          pop_q, pop_d;
  logic          ovr_q, ovr_d;
  logic          ferr_q, ferr_d;

  logic                          fifo_full, fifo_empty;
  logic [7:0]                    fifo_head;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          hit_data, hit_stat, act;
  logic [7:0]                    status;
  logic                          unused_wdata;

  assign sync_d = {sync_q[0], rx};
  assign line   = sync_q[1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    armed_d  = armed_q;
    push_d   = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: begin
        // Only a high-to-low edge starts a frame; a held-low line stays unarmed.
        if (!armed_q) begin
          armed_d = line;
        end else if (!line) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end
      end
      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!line) begin
          state_d = DATA;
          cnt_d   = CNT_FULL;
          bit_d   = 3'd0;
        end else begin
          state_d = IDLE;
          armed_d = 1'b0;
        end
      end
      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {line, shift_q[7:1]};
          cnt_d   = CNT_FULL;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d  = IDLE;
          armed_d  = 1'b0;
          push_d   = line;
          ferr_set = !line;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      armed_q <= 1'b0;
      push_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
      push_q  <= push_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push_q),
    .push_dat (shift_q),
    .pop      (pop_q),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    status           = 8'h00;
    status[ST_VALID] = !fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_OVR]   = ovr_q;
    status[ST_FERR]  = ferr_q;
  end

  assign hit_data     = (mmio_addr == BASE_ADDR + OFS_DATA);
  assign hit_stat     = (mmio_addr == BASE_ADDR + OFS_STATUS);
  assign act          = mmio_req && (hit_data || hit_stat) && !served_q;
  assign unused_wdata = ^{mmio_data[7:4], mmio_data[1:0]};

  always_comb begin
    served_d = mmio_req && (served_q || act);
    done_d   = act;
    pop_d    = 1'b0;
    rdata_d  = rdata_q;
    ovr_d    = ovr_q;
    ferr_d   = ferr_q;
    if (act && !mmio_write) begin
      if (hit_data) begin
        rdata_d = fifo_empty ? 8'h00 : fifo_head;
        pop_d   = !fifo_empty;
      end else begin
        rdata_d = status;
      end
    end
    if (act && mmio_write && hit_stat) begin
      if (mmio_data[ST_OVR])  ovr_d  = 1'b0;
      if (mmio_data[ST_FERR]) ferr_d = 1'b0;
    end
    // A new event in the same cycle as a clear wins, so no error is lost.
    if (push_q && fifo_full && !pop_q) ovr_d = 1'b1;
    if (ferr_set) ferr_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      served_q <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= 8'h00;
      pop_q    <= 1'b0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      served_q <= served_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      pop_q    <= pop_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
    end
  end

  assign mmio_done  = done_q;
  assign mmio_rdata = rdata_q;
  assign rx_ready   = (fifo_count != '0);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames on rx, register accesses over MMIO.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_uart_rx;

  localparam int          CPB    = 234;
  localparam logic [15:0] A_DATA = 16'hFF10;
  localparam logic [15:0] A_STAT = 16'hFF11;

  logic        clock      = 1'b0;
  logic        reset      = 1'b1;
  logic        rx         = 1'b1;
  logic [15:0] mmio_addr  = 16'h0000;
  logic [7:0]  mmio_data  = 8'h00;
  logic        mmio_write = 1'b0;
  logic        mmio_req   = 1'b0;
  logic        mmio_done;
  logic [7:0]  mmio_rdata;
  logic        rx_ready;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] rd;
  int         lat;

  uart_rx dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .mmio_addr  (mmio_addr),
    .mmio_data  (mmio_data),
    .mmio_write (mmio_write),
    .mmio_req   (mmio_req),
    .mmio_done  (mmio_done),
    .mmio_rdata (mmio_rdata),
    .rx_ready   (rx_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One frame; edge E0 is the one just before the start bit is driven.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clock); #1; rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clock);
      #1; rx = b[i];
    end
    repeat (CPB) @(posedge clock);
    #1; rx = stop_bit;
    repeat (CPB) @(posedge clock);
    #1; rx = 1'b1;
    repeat (4) @(posedge clock);
    #1;
  endtask

  // lat = cycles from req to done, 0 if done never came within the bound.
  task automatic xfer(input logic [15:0] addr, input logic wr, input logic [7:0] wdata,
                      output logic [7:0] rdata, output int latency);
    mmio_addr  = addr;
    mmio_write = wr;
    mmio_data  = wdata;
    mmio_req   = 1'b1;
    latency    = 0;
    rdata      = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clock); #1;
      if (mmio_done) begin
        latency = i;
        rdata   = mmio_rdata;
        break;
      end
    end
    mmio_req = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    logic [7:0] d;
    int         l;
    xfer(addr, 1'b0, 8'h00, d, l);
    check(tag, {l[7:0], d}, {8'd1, exp});
  endtask

  task automatic wr_chk(input string tag, input logic [15:0] addr, input logic [7:0] wdata);
    logic [7:0] d;
    int         l;
    xfer(addr, 1'b1, wdata, d, l);
    check(tag, l, 1);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    logic [7:0] got;

    repeat (3) @(posedge clock);
    #1; reset = 1'b0;
    @(posedge clock); #1;
    check("reset_rx_ready", rx_ready, 0);
    check("reset_done", mmio_done, 0);
    check("reset_rdata", mmio_rdata, 0);
    rd_chk("reset_status", A_STAT, 8'h00);

    // Single byte with push/ready timing
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge clock);
        repeat (2226) @(posedge clock);
        #1; check("rdy_before_push", rx_ready, 0);
        @(posedge clock); #1;
        check("rdy_after_push", rx_ready, 1);
      end
    join
    rd_chk("single_data", A_DATA, 8'hA5);
    rd_chk("single_status", A_STAT, 8'h00);
    wr_chk("wr_data_done", A_DATA, 8'hFF);
    xfer(16'hFF12, 1'b0, 8'h00, rd, lat);
    check("oor_no_done", lat, 0);

    // Glitch shorter than half a bit
    @(posedge clock); #1; rx = 1'b0;
    repeat (50) @(posedge clock);
    #1; rx = 1'b1;
    repeat (300) @(posedge clock);
    #1;
    rd_chk("glitch_status", A_STAT, 8'h00);

    // Framing error and write-1-to-clear
    send_frame(8'h3C, 1'b0);
    check("ferr_rx_ready", rx_ready, 0);
    rd_chk("ferr_status", A_STAT, 8'h08);
    wr_chk("ferr_clear_wr", A_STAT, 8'h08);
    rd_chk("ferr_cleared", A_STAT, 8'h00);

    // Overrun: 17 bytes into a 16-entry FIFO
    for (int b = 0; b < 17; b++) send_frame(8'(b), 1'b1);
    rd_chk("ovr_status", A_STAT, 8'h07);
    wr_chk("ovr_clear_wr", A_STAT, 8'h04);
    rd_chk("ovr_cleared", A_STAT, 8'h03);

    // Full FIFO, DATA read timed so its pop lands on the push edge
    fork
      send_frame(8'h11, 1'b1);
      begin
        @(posedge clock);
        repeat (2225) @(posedge clock);
        #1;
        xfer(A_DATA, 1'b0, 8'h00, rd, lat);
        check("simul_read", {lat[7:0], rd}, {8'd1, 8'h00});
      end
    join
    rd_chk("simul_status", A_STAT, 8'h03);
    for (int i = 1; i < 16; i++) rd_chk("drain_data", A_DATA, 8'(i));
    rd_chk("drain_last", A_DATA, 8'h11);
    rd_chk("empty_read", A_DATA, 8'h00);
    rd_chk("drained_status", A_STAT, 8'h00);

    // Held request: one done and one pop
    send_frame(8'h5A, 1'b1);
    send_frame(8'hC3, 1'b1);
    mmio_addr  = A_DATA;
    mmio_write = 1'b0;
    mmio_req   = 1'b1;
    ndone      = 0;
    got        = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (mmio_done) begin
        ndone++;
        got = mmio_rdata;
      end
    end
    mmio_req = 1'b0;
    @(posedge clock); #1;
    if (mmio_done) ndone++;
    check("held_done_count", ndone, 1);
    check("held_rdata", got, 8'h5A);
    rd_chk("held_status", A_STAT, 8'h01);

    // Reset in the middle of a frame
    @(posedge clock); #1; rx = 1'b0;
    repeat (CPB) @(posedge clock);
    #1; rx = 1'b1;
    repeat (CPB) @(posedge clock);
    #1; rx = 1'b0;
    repeat (100) @(posedge clock);
    #1; reset = 1'b1;
    repeat (2) @(posedge clock);
    #1; reset = 1'b0; rx = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    check("rst_rx_ready", rx_ready, 0);
    check("rst_done", mmio_done, 0);
    check("rst_rdata", mmio_rdata, 0);
    rd_chk("rst_status", A_STAT, 8'h00);
    repeat (2500) @(posedge clock);
    #1;
    rd_chk("rst_no_partial", A_STAT, 8'h00);
    send_frame(8'h96, 1'b1);
    rd_chk("post_rst_data", A_DATA, 8'h96);
    rd_chk("post_rst_status", A_STAT, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
